mult_div_sequencer: RTL

MULT_DIV_SEQUENCER -- requirements
Module: mult_div_sequencer

---
 rtl/mips_pkg.sv | 28 ++
 rtl/md_datapath.sv | 127 ++++++++++++
 rtl/mult_div_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the ALU control decoder and the
// multiply/divide sequencer.
//   ALU_MULT / ALU_DIV : ALU control encodings for the HI/LO operations
//   md_state_e         : multiply/divide sequencer state encoding
//   magnitude()        : absolute value of a possibly-signed operand
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_MULT = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } md_state_e;

  // Two's-complement magnitude when the operand is treated as signed;
  // unsigned operands pass through untouched.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                 input logic            sgn);
    return (sgn && x[XLEN-1]) ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/md_datapath.sv
// Multiply/divide datapath: operand latches, 64-bit accumulator used both
// for shift-add multiplication and restoring division, sign correction,
// and the architectural HI/LO registers.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : latch raw operands and sign mode (accepting edge)
//   is_signed_i  : sign mode to latch with the operands
//   op_a_i/op_b_i: raw operands
//   is_div_i     : operation of the sequence in flight (1 = divide)
//   prep_i       : convert operands to magnitudes, seed accumulator
//   step_i       : perform one multiply or divide iteration
//   fix_i        : sign-correct the result and write HI/LO
//   b_zero_o     : latched divisor is zero
//   hi_o/lo_o    : HI/LO registers
module md_datapath
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            is_signed_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            is_div_i,
  input  logic            prep_i,
  input  logic            step_i,
  input  logic            fix_i,
  output logic            b_zero_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic              sgn_q, sgn_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [XLEN:0]     mult_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     trial;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // Multiply: accumulator = {partial product, remaining multiplier bits}.
  // Divide: accumulator = {partial remainder, dividend/quotient bits}.
  // The extra bit on each adder catches the carry or the borrow.
  assign mult_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
  assign rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign trial     = rem_shift - {1'b0, b_q};

  assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1)
                              : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (load_i) begin
      a_d   = op_a_i;
      b_d   = op_b_i;
      sgn_d = is_signed_i;
    end
    if (prep_i) begin
      a_d       = magnitude(a_q, sgn_q);
      b_d       = magnitude(b_q, sgn_q);
      neg_res_d = sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
      neg_rem_d = sgn_q & a_q[XLEN-1];
      acc_d     = is_div_i ? {{XLEN{1'b0}}, magnitude(a_q, sgn_q)}
                           : {{XLEN{1'b0}}, magnitude(b_q, sgn_q)};
    end
    if (step_i) begin
      if (!is_div_i) begin
        acc_d = acc_q[0] ? {mult_sum, acc_q[XLEN-1:1]}
                         : {1'b0, acc_q[2*XLEN-1:1]};
      end else if (!trial[XLEN]) begin
        acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end
    if (fix_i) begin
      if (!is_div_i) begin
        hi_d = prod_fix[2*XLEN-1:XLEN];
        lo_d = prod_fix[XLEN-1:0];
      end else begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign b_zero_o = (b_q == '0);
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

// File: rtl/mult_div_sequencer.sv
// Multi-cycle multiply/divide unit for the HI/LO instructions. The FSM and
// iteration counter live here; arithmetic lives in md_datapath.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, alu_ctrl   : operation request and op select (mult/div)
//   is_signed         : two's-complement operands when 1
//   op_a, op_b        : multiplicand/dividend, multiplier/divisor
//   flush             : abort the operation in flight
//   busy, done        : pipeline stall, one-cycle completion pulse
//   div_by_zero       : qualifies done for a zero divisor
//   hi, lo            : HI/LO registers
module mult_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mips_pkg::*;

  md_state_e  state_q;
  logic [4:0] cnt_q;
  logic       busy_q, done_q, dbz_q, is_div_q;
  logic       accept, b_zero;
  logic       prep_en, step_en, fix_en;

  // Flush wins over a simultaneous start; unknown op codes are dropped.
  assign accept = (state_q == IDLE) && start && !flush &&
                  ((alu_ctrl == ALU_MULT) || (alu_ctrl == ALU_DIV));

  // A flush must not let the datapath advance or touch HI/LO.
  assign prep_en = (state_q == PREP) && !flush;
  assign step_en = (state_q == RUN)  && !flush;
  assign fix_en  = (state_q == FIX)  && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (state_q != IDLE && flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              state_q  <= PREP;
              busy_q   <= 1'b1;
              is_div_q <= (alu_ctrl == ALU_DIV);
            end
          end
          PREP: begin
            // A zero divisor skips the iterations entirely.
            if (is_div_q && b_zero) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= RUN;
              cnt_q   <= 5'd31;
            end
          end
          RUN: begin
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
              state_q <= FIX;
            end
          end
          FIX: begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  md_datapath u_datapath (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .is_signed_i (is_signed),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .is_div_i    (is_div_q),
    .prep_i      (prep_en),
    .step_i      (step_en),
    .fix_i       (fix_en),
    .b_zero_o    (b_zero),
    .hi_o        (hi),
    .lo_o        (lo)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
